// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//
// Shares one register-interface slave port between NumReq requesters using
// round-robin arbitration. A granted request is latched and driven to the
// slave until the slave returns ready. The response is then routed only to
// the owning requester. A watchdog turns a hung slave into an error response
// after TimeoutCycles BUSY cycles. TimeoutCycles = 0 disables the watchdog.
//
// The request and response structs are flattened into one port per field.
// Each port name is <struct port>_<field>. Per-requester fields are packed
// arrays indexed by requester number.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   reg_req_i_*          requester requests (valid, write, addr, wdata, wstrb)
//   reg_rsp_o_*          requester responses (ready, rdata, error)
//   reg_req_o_*          request to the shared slave
//   reg_rsp_i_*          response from the shared slave
//   gnt_idx_o            index of the current or last granted requester
//   busy_o               high while a transaction is in flight
//   timeout_o            one-cycle pulse when a timeout response is issued
//   dbg_state_o          FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a requester asserts valid with stable fields and keeps them until
// it sees ready. Ready is a single-cycle pulse that completes the transfer.
// The slave side follows the same rule: reg_req_o_valid stays high with
// stable fields until reg_rsp_i_ready is sampled high.
// ---------------------------------------------------------------------------
module reg_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 256,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumReq-1:0]                      reg_req_i_valid,
  input  logic [NumReq-1:0]                      reg_req_i_write,
  input  logic [NumReq-1:0][AddrWidth-1:0]       reg_req_i_addr,
  input  logic [NumReq-1:0][DataWidth-1:0]       reg_req_i_wdata,
  input  logic [NumReq-1:0][DataWidth/8-1:0]     reg_req_i_wstrb,
  output logic [NumReq-1:0]                      reg_rsp_o_ready,
  output logic [NumReq-1:0][DataWidth-1:0]       reg_rsp_o_rdata,
  output logic [NumReq-1:0]                      reg_rsp_o_error,
  output logic                                   reg_req_o_valid,
  output logic                                   reg_req_o_write,
  output logic [AddrWidth-1:0]                   reg_req_o_addr,
  output logic [DataWidth-1:0]                   reg_req_o_wdata,
  output logic [DataWidth/8-1:0]                 reg_req_o_wstrb,
  input  logic                                   reg_rsp_i_ready,
  input  logic [DataWidth-1:0]                   reg_rsp_i_rdata,
  input  logic                                   reg_rsp_i_error,
  output logic [$clog2(NumReq)-1:0]              gnt_idx_o,
  output logic                                   busy_o,
  output logic                                   timeout_o,
  output logic                                   dbg_state_o
);

  localparam int IdxW  = $clog2(NumReq);
  localparam int StrbW = DataWidth / 8;
  // A zero-cycle timeout still needs a legal one-bit counter.
  localparam int CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_write;
  logic [AddrWidth-1:0]  r_addr;
  logic [DataWidth-1:0]  r_wdata;
  logic [StrbW-1:0]      r_wstrb;
  logic [IdxW-1:0]       r_gnt_idx;
  logic [IdxW-1:0]       r_last_gnt;
  logic [CntW-1:0]       r_cnt;

  logic                  w_win_found;
  logic [IdxW-1:0]       w_win_idx;
  logic                  w_timeout;

  // Requester index k positions after base, wrapping at NumReq.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int k);
    return IdxW'((int'(base) + k) % NumReq);
  endfunction

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= NumReq; k++) begin
      if (!w_win_found && reg_req_i_valid[rr_idx(r_last_gnt, k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = rr_idx(r_last_gnt, k);
      end
    end
  end

  // The slave's ready takes priority over the watchdog on the final cycle.
  assign w_timeout = (TimeoutCycles != 0) && (r_state == S_BUSY) &&
                     (r_cnt == CntLast) && !reg_rsp_i_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_gnt_idx  <= '0;
      r_last_gnt <= IdxW'(NumReq - 1);
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_win_found) begin
        r_write    <= reg_req_i_write[w_win_idx];
        r_addr     <= reg_req_i_addr[w_win_idx];
        r_wdata    <= reg_req_i_wdata[w_win_idx];
        r_wstrb    <= reg_req_i_wstrb[w_win_idx];
        r_gnt_idx  <= w_win_idx;
        r_last_gnt <= w_win_idx;
        r_cnt      <= '0;
      end else if (r_state == S_BUSY && r_cnt != CntMax) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    reg_req_o_valid = 1'b0;
    reg_req_o_write = 1'b0;
    reg_req_o_addr  = '0;
    reg_req_o_wdata = '0;
    reg_req_o_wstrb = '0;
    reg_rsp_o_ready = '0;
    reg_rsp_o_rdata = '0;
    reg_rsp_o_error = '0;
    timeout_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        reg_req_o_valid = 1'b1;
        reg_req_o_write = r_write;
        reg_req_o_addr  = r_addr;
        reg_req_o_wdata = r_wdata;
        reg_req_o_wstrb = r_wstrb;
        if (reg_rsp_i_ready) begin
          reg_rsp_o_ready[r_gnt_idx] = 1'b1;
          reg_rsp_o_rdata[r_gnt_idx] = reg_rsp_i_rdata;
          reg_rsp_o_error[r_gnt_idx] = reg_rsp_i_error;
          w_state_nxt                = S_IDLE;
        end else if (w_timeout) begin
          reg_rsp_o_ready[r_gnt_idx] = 1'b1;
          reg_rsp_o_error[r_gnt_idx] = 1'b1;
          timeout_o                  = 1'b1;
          w_state_nxt                = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign gnt_idx_o   = r_gnt_idx;
  assign busy_o      = (r_state == S_BUSY);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_arbiter
//
// Self-checking bench for reg_bus_arbiter with two requesters and an 8-cycle
// timeout. Each expected response record {idx, rdata, error, timeout} is
// queued when the stimulus is driven. The record is popped and compared when
// a ready pulse appears on a requester port. Inputs change 1 ns after the
// rising edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_bus_arbiter;

  localparam int TO = 8;
  localparam int W  = 1 + 32 + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_write;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic [1:0]       rsp_ready, rsp_error;
  logic [1:0][31:0] rsp_rdata;
  logic             mo_valid, mo_write;
  logic [31:0]      mo_addr, mo_wdata;
  logic [3:0]       mo_wstrb;
  logic             slv_ready, slv_error, use_addr_rdata;
  logic [31:0]      slv_rdata_fix, slv_rdata;
  logic             gnt_idx, busy, timeout, dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Simple slave model: either a fixed read value or one derived from the address.
  assign slv_rdata = use_addr_rdata ? (mo_addr ^ 32'hF00D_0000) : slv_rdata_fix;

  reg_bus_arbiter #(.NumReq(2), .TimeoutCycles(TO), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .reg_req_i_valid (req_valid),
    .reg_req_i_write (req_write),
    .reg_req_i_addr  (req_addr),
    .reg_req_i_wdata (req_wdata),
    .reg_req_i_wstrb (req_wstrb),
    .reg_rsp_o_ready (rsp_ready),
    .reg_rsp_o_rdata (rsp_rdata),
    .reg_rsp_o_error (rsp_error),
    .reg_req_o_valid (mo_valid),
    .reg_req_o_write (mo_write),
    .reg_req_o_addr  (mo_addr),
    .reg_req_o_wdata (mo_wdata),
    .reg_req_o_wstrb (mo_wstrb),
    .reg_rsp_i_ready (slv_ready),
    .reg_rsp_i_rdata (slv_rdata),
    .reg_rsp_i_error (slv_error),
    .gnt_idx_o       (gnt_idx),
    .busy_o          (busy),
    .timeout_o       (timeout),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] rec(input logic idx, input logic [31:0] rdata,
                                       input logic err, input logic to);
    return {idx, rdata, err, to};
  endfunction

  // Scoreboard: every ready pulse must match the oldest expected record, and
  // requesters without a ready pulse must see an all-zero response.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (rsp_ready[i]) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            logic [W-1:0] exp_rec;
            exp_rec = exp_q.pop_front();
            check("rsp", {i[0], rsp_rdata[i], rsp_error[i], timeout}, exp_rec);
          end
        end else begin
          check("rsp_quiet", {rsp_rdata[i], rsp_error[i]}, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    req_wstrb[idx] = wstrb;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    slv_ready = 1'b0; slv_error = 1'b0; slv_rdata_fix = '0; use_addr_rdata = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    busy, 0);
    check("rst_gnt",     gnt_idx, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rsp",     {rsp_ready, rsp_rdata, rsp_error}, 0);
    check("rst_req_o",   {mo_valid, mo_write, mo_addr, mo_wdata, mo_wstrb}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from requester 0 with a slave that is ready immediately.
    step();
    slv_ready = 1'b1; slv_rdata_fix = 32'hCAFE_0001; slv_error = 1'b0;
    drive_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    exp_q.push_back(rec(1'b0, 32'hCAFE_0001, 1'b0, 1'b0));
    @(negedge clk);
    check("sr_no_comb_path", {mo_valid, busy}, 0);
    @(negedge clk);
    check("sr_req_o", {mo_valid, mo_write, mo_addr}, {1'b1, 1'b0, 32'h10});
    check("sr_gnt",   gnt_idx, 0);
    check("sr_ready", rsp_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("sr_idle_req_o", {mo_valid, mo_addr, busy}, 0);
    check("sr_gnt_hold",   gnt_idx, 0);

    // Write from requester 1 with five wait states.
    step();
    slv_ready = 1'b0;
    drive_req(1, 1'b1, 32'h24, 32'hA5A5_A5A5, 4'hF);
    exp_q.push_back(rec(1'b1, 32'hCAFE_0001, 1'b0, 1'b0));
    for (int b = 1; b <= 6; b++) begin
      step();
      slv_ready = (b == 6);
      @(negedge clk);
      check("ws_busy",  busy, 1);
      check("ws_hold",  {mo_valid, mo_write, mo_addr, mo_wdata, mo_wstrb},
                        {1'b1, 1'b1, 32'h24, 32'hA5A5_A5A5, 4'hF});
      check("ws_ready", rsp_ready, (b == 6) ? 2'b10 : 2'b00);
      check("ws_gnt",   gnt_idx, 1);
    end
    step();
    req_valid[1] = 1'b0; slv_ready = 1'b0;

    // Timeout: slave never answers a read from requester 0.
    drive_req(0, 1'b0, 32'h30, 32'h0, 4'h0);
    exp_q.push_back(rec(1'b0, 32'h0, 1'b1, 1'b1));
    for (int b = 1; b <= TO; b++) begin
      step();
      @(negedge clk);
      check("to_busy",  busy, 1);
      check("to_pulse", timeout, (b == TO));
      check("to_ready", rsp_ready, (b == TO) ? 2'b01 : 2'b00);
    end
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("to_back_idle", {busy, mo_valid, timeout}, 0);

    // Timeout tie: slave answers on the last allowed cycle and wins.
    step();
    slv_rdata_fix = 32'h1234_5678; slv_error = 1'b1;
    drive_req(0, 1'b0, 32'h34, 32'h0, 4'h0);
    exp_q.push_back(rec(1'b0, 32'h1234_5678, 1'b1, 1'b0));
    for (int b = 1; b <= TO; b++) begin
      step();
      slv_ready = (b == TO);
      @(negedge clk);
      check("tie_busy",    busy, 1);
      check("tie_timeout", timeout, 0);
    end
    step();
    req_valid[0] = 1'b0; slv_ready = 1'b0; slv_error = 1'b0;
    @(negedge clk);
    check("tie_back_idle", busy, 0);

    // Reset in the middle of a stalled transaction from requester 1.
    step();
    drive_req(1, 1'b0, 32'h50, 32'h0, 4'h0);
    for (int b = 1; b <= 2; b++) begin
      step();
      @(negedge clk);
      check("rm_busy", busy, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_async_busy",  busy, 0);
    check("rm_async_req_o", mo_valid, 0);
    check("rm_async_ready", rsp_ready, 0);
    check("rm_async_gnt",   gnt_idx, 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fairness: both requesters hold valid; slave always ready.
    step();
    slv_ready = 1'b1; use_addr_rdata = 1'b1;
    drive_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    drive_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
    exp_q.push_back(rec(1'b0, 32'hF00D_0040, 1'b0, 1'b0));
    exp_q.push_back(rec(1'b1, 32'hF00D_0044, 1'b0, 1'b0));
    exp_q.push_back(rec(1'b0, 32'hF00D_0040, 1'b0, 1'b0));
    exp_q.push_back(rec(1'b1, 32'hF00D_0044, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_busy", busy, k % 2);
      check("fair_gnt",  gnt_idx, (k == 0) ? 0 : ((k - 1) / 2) % 2);
    end
    step();
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("fair_idle", busy, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Round-robin arbiter that shares one register-interface slave port between `NumReq` register-interface requesters. It sits between the bus subsystem's peripheral register outputs and a shared peripheral register bank. Typical requesters are the CPU path and a debug or DMA path. It latches each granted request, holds the slave transaction until `ready`, and returns the response only to the owning requester. A timeout watchdog converts a hung slave into an error response.

## Interface
- `NumReq`, default 2: number of requester ports; must be ≥ 2.
- `TimeoutCycles`, default 256: maximum BUSY cycles before a forced error response; 0 disables the timeout.
- `reg_req_t`, default `core_v_mcu_reg_pkg::reg_req_t`: request struct with fields valid, write, addr, wdata, wstrb.
- `reg_rsp_t`, default `core_v_mcu_reg_pkg::reg_resp_t`: response struct with fields ready, rdata, error.
- `clk_i`  in  1  single clock; all state is on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `reg_req_i`  in  `reg_req_t [NumReq]`  requester requests.
- `reg_rsp_o`  out  `reg_rsp_t [NumReq]`  requester responses.
- `reg_req_o`  out  `reg_req_t`  request to the shared slave.
- `reg_rsp_i`  in  `reg_rsp_t`  response from the shared slave.
- `gnt_idx_o`  out  `$clog2(NumReq)`  index of the current or last granted requester.
- `busy_o`  out  1  high while in BUSY.
- `timeout_o`  out  1  one-cycle pulse when a timeout response is issued.

## Operation
- FSM states:
  - IDLE: no transaction in flight; arbitration happens here.
  - BUSY: the latched request is driven to the slave.
- IDLE → BUSY:
  - Any `reg_req_i[i].valid` is high.
  - Winner is the first valid index searching from `last_gnt+1` upward, modulo `NumReq`.
  - On the transition edge, register the winner's write, addr, wdata and wstrb, plus the winner index.
  - Set `last_gnt` to the winner index and clear the timeout counter.
- BUSY, slave completes:
  - `reg_req_o` = latched fields with valid=1.
  - Completion condition: `reg_rsp_i.ready`=1.
  - Same cycle: `reg_rsp_o[gnt]` = {ready 1, rdata `reg_rsp_i.rdata`, error `reg_rsp_i.error`}.
  - Next state: IDLE.
- BUSY, timeout:
  - Condition: counter == `TimeoutCycles-1` and `reg_rsp_i.ready`=0.
  - Same cycle: `reg_rsp_o[gnt]` = {ready 1, rdata 0, error 1} and `timeout_o`=1.
  - Next state: IDLE; `reg_req_o.valid` drops on the following cycle.
  - Otherwise the counter increments by one each BUSY cycle.
- If ready and the timeout condition coincide, the slave response wins and `timeout_o` stays 0.
- Non-granted requesters, and all requesters in IDLE, see `reg_rsp_o` = all-zero.
- A requester dropping valid while granted is a protocol violation. The latched request still completes and the ready pulse is still sent.
- In IDLE, `reg_req_o` = all-zero.
- Counter width is `$clog2(TimeoutCycles+1)`. The counter saturates and never wraps.

## Timing
- Reset values:
  - state IDLE; `last_gnt` = `NumReq-1`, so index 0 wins first.
  - latched request = 0; counter = 0; `gnt_idx_o` = 0.
  - `busy_o` = 0; `timeout_o` = 0; all `reg_rsp_o` = 0; `reg_req_o` = 0.
- Reset asserted mid-BUSY: outputs drop to reset values immediately (asynchronously). No response is delivered for the aborted transaction.
- Latency:
  - Request seen in IDLE at cycle N → `reg_req_o.valid` at N+1.
  - With a combinational slave ready at N+1, `reg_rsp_o.ready` is at N+1.
- Minimum 2 cycles per transaction, including one IDLE arbitration cycle.
- Back-to-back requests from different requesters alternate.
- `gnt_idx_o` updates on the IDLE→BUSY edge and holds through the following IDLE.
- There is no combinational path from `reg_req_i` to `reg_req_o`. There is a combinational path from `reg_rsp_i` to `reg_rsp_o`.

## Test plan
- **Single read:**
  - Stimulus: req0 reads addr 0x10; slave ready in its first BUSY cycle with rdata 0xCAFE_0001.
  - Required: `reg_req_o.valid` one cycle after req0 valid; `reg_rsp_o[0]` = {1, 0xCAFE_0001, 0}; `reg_rsp_o[1]` = 0.
- **Fairness:**
  - Stimulus: req0 and req1 both valid continuously after reset; slave always ready.
  - Required: grant order 0,1,0,1; each grant takes 2 cycles; `gnt_idx_o` toggles.
- **Wait states:**
  - Stimulus: req1 writes 0xA5A5_A5A5 with wstrb 0xF; slave withholds ready for 5 cycles.
  - Required: `reg_req_o` fields stable for 6 BUSY cycles; ready pulse to req1 only on cycle 6.
- **Timeout:**
  - Stimulus: `TimeoutCycles`=8; slave never ready.
  - Required: on the 8th BUSY cycle `reg_rsp_o[0]` = {1, 0, 1} and `timeout_o`=1; FSM back in IDLE.
- **Timeout tie:**
  - Stimulus: `TimeoutCycles`=8; slave ready exactly on the 8th BUSY cycle.
  - Required: slave rdata and error forwarded; `timeout_o`=0.
- **Reset mid-op:**
  - Stimulus: `rst_ni` low during BUSY.
  - Required: `busy_o`, `reg_req_o.valid` and all ready outputs are 0 immediately. After release, the first grant goes to index 0.
